// File: rtl/tl_tx_fc_gate.sv
// tl_tx_fc_gate: credit and retry-space gate between the TL TX arbiter and DLL TX.
module tl_tx_fc_gate #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int CREDIT_DEPTH    = 12,
  parameter int RETRY_DEPTH_LG2 = 8
) (
  input  logic                       sclk,
  input  logic                       srst,
  input  logic                       tlp_valid_i,
  output logic                       tlp_ready_o,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  input  logic [1:0]                 tlp_type_i,
  input  logic [3:0]                 tlp_dw_i,
  input  logic [3:0]                 tlp_pld_dw_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_p_h_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_p_d_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_np_h_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_cpl_h_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_cpl_d_i,
  input  logic                       ep_cl_en_i,
  input  logic [RETRY_DEPTH_LG2-1:0] retry_buffer_leftover_cnt_i,
  output logic [PIPE_DATA_WIDTH-1:0] tl2dll_data_o,
  output logic [2:0]                 tl2dll_en_o,
  output logic                       fc_init_done_o,
  output logic                       stall_credit_o
);
  typedef enum logic {FC_WAIT, RUN} state_t;
  // Credit field slots: 0 P_H, 1 P_D, 2 NP_H, 3 CPL_H, 4 CPL_D.
  state_t                      state, state_nxt;
  logic [CREDIT_DEPTH-1:0]     cl [5];
  logic [CREDIT_DEPTH-1:0]     cc [5];
  logic [CREDIT_DEPTH-1:0]     lim_in [5];
  logic [4:0]                  inf;
  logic                        hold_full, run, accept, issue, h_ok, d_ok, retry_ok;
  logic [PIPE_DATA_WIDTH-1:0]  hold_data;
  logic [1:0]                  hold_type;
  logic [3:0]                  hold_dw, hold_pld;
  logic [4:0]                  pld_sum;
  logic [CREDIT_DEPTH-1:0]     need_d;
  logic [2:0]                  h_idx, d_idx;

  function automatic logic passes(input logic [CREDIT_DEPTH-1:0] lim, input logic [CREDIT_DEPTH-1:0] used,
                                  input logic [CREDIT_DEPTH-1:0] need, input logic is_inf);
    logic [CREDIT_DEPTH-1:0] diff;
    diff = lim - (used + need);
    return is_inf || !diff[CREDIT_DEPTH-1];
  endfunction

  assign lim_in = '{ep_cl_p_h_i, ep_cl_p_d_i, ep_cl_np_h_i, ep_cl_cpl_h_i, ep_cl_cpl_d_i};

  always_ff @(posedge sclk)
    state <= srst ? FC_WAIT : state_nxt;

  always_comb
    state_nxt = (state == FC_WAIT && ep_cl_en_i) ? RUN : state;

  always_comb begin
    run            = state == RUN;
    tlp_ready_o    = run && !hold_full;
    fc_init_done_o = run;
    stall_credit_o = hold_full && !issue;
  end

  always_comb begin
    h_idx    = hold_type == 2'd0 ? 3'd0 : hold_type == 2'd1 ? 3'd2 : 3'd3;
    d_idx    = hold_type == 2'd0 ? 3'd1 : 3'd4;
    pld_sum  = {1'b0, hold_pld} + 5'd3;
    need_d   = CREDIT_DEPTH'(pld_sum[4:2]);
    h_ok     = passes(cl[h_idx], cc[h_idx], CREDIT_DEPTH'(1), inf[h_idx]);
    d_ok     = hold_type == 2'd1 || passes(cl[d_idx], cc[d_idx], need_d, inf[d_idx]);
    retry_ok = retry_buffer_leftover_cnt_i >= RETRY_DEPTH_LG2'(hold_dw);
    issue    = hold_full && h_ok && d_ok && retry_ok;
    accept   = tlp_valid_i && tlp_ready_o;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      for (int i = 0; i < 5; i++) begin
        cl[i] <= '0;
        cc[i] <= '0;
      end
      inf           <= '0;
      hold_full     <= 1'b0;
      hold_data     <= '0;
      hold_type     <= '0;
      hold_dw       <= '0;
      hold_pld      <= '0;
      tl2dll_data_o <= '0;
      tl2dll_en_o   <= '0;
    end else begin
      // The first limit set defines which fields are infinite for the whole link-up.
      if (ep_cl_en_i)
        for (int i = 0; i < 5; i++) begin
          if (!run || !inf[i]) cl[i] <= lim_in[i];
          if (!run) inf[i] <= lim_in[i] == '0;
        end
      tl2dll_en_o <= issue ? 3'(3'd1 << hold_type) : 3'd0;
      if (issue) begin
        tl2dll_data_o <= hold_data;
        cc[h_idx]     <= cc[h_idx] + CREDIT_DEPTH'(1);
        if (hold_type != 2'd1) cc[d_idx] <= cc[d_idx] + need_d;
        hold_full     <= 1'b0;
      end
      if (accept) begin
        hold_full <= tlp_type_i != 2'd3;
        hold_data <= tlp_data_i;
        hold_type <= tlp_type_i;
        hold_dw   <= tlp_dw_i;
        hold_pld  <= tlp_pld_dw_i;
      end
    end
  end
endmodule

// File: tb/tb_tl_tx_fc_gate.sv
// tb_tl_tx_fc_gate: vector table, directed corner sequences and randomized run against a credit model.
module tb_tl_tx_fc_gate;
  localparam int W = 256, CD = 12, RD = 8;
  logic          sclk = 0, srst = 1;
  logic          tlp_valid_i = 0, tlp_ready_o, ep_cl_en_i = 0, fc_init_done_o, stall_credit_o;
  logic [W-1:0]  tlp_data_i = '0, tl2dll_data_o;
  logic [1:0]    tlp_type_i = 0;
  logic [3:0]    tlp_dw_i = 0, tlp_pld_dw_i = 0;
  logic [CD-1:0] ep_cl_p_h_i = 0, ep_cl_p_d_i = 0, ep_cl_np_h_i = 0, ep_cl_cpl_h_i = 0, ep_cl_cpl_d_i = 0;
  logic [RD-1:0] retry_buffer_leftover_cnt_i = 0;
  logic [2:0]    tl2dll_en_o;

  tl_tx_fc_gate #(.PIPE_DATA_WIDTH(W), .CREDIT_DEPTH(CD), .RETRY_DEPTH_LG2(RD)) dut (
    .sclk(sclk), .srst(srst), .tlp_valid_i(tlp_valid_i), .tlp_ready_o(tlp_ready_o),
    .tlp_data_i(tlp_data_i), .tlp_type_i(tlp_type_i), .tlp_dw_i(tlp_dw_i), .tlp_pld_dw_i(tlp_pld_dw_i),
    .ep_cl_p_h_i(ep_cl_p_h_i), .ep_cl_p_d_i(ep_cl_p_d_i), .ep_cl_np_h_i(ep_cl_np_h_i),
    .ep_cl_cpl_h_i(ep_cl_cpl_h_i), .ep_cl_cpl_d_i(ep_cl_cpl_d_i), .ep_cl_en_i(ep_cl_en_i),
    .retry_buffer_leftover_cnt_i(retry_buffer_leftover_cnt_i), .tl2dll_data_o(tl2dll_data_o),
    .tl2dll_en_o(tl2dll_en_o), .fc_init_done_o(fc_init_done_o), .stall_credit_o(stall_credit_o));

  always #5 sclk = ~sclk;

  int checks = 0, errors = 0, n_strobe = 0;

  // Reference model: limits/consumed kept as plain integers per credit field (P_H,P_D,NP_H,CPL_H,CPL_D).
  int       m_lim[5], m_cc[5];
  bit       m_inf[5];
  bit       m_run, m_full;
  int       m_type, m_dw, m_pld;
  logic [W-1:0] m_hdata, m_data;
  bit [2:0] m_en;

  function automatic void m_reset();
    for (int i = 0; i < 5; i++) begin m_lim[i] = 0; m_cc[i] = 0; m_inf[i] = 0; end
    m_run = 0; m_full = 0; m_type = 0; m_dw = 0; m_pld = 0;
    m_hdata = '0; m_data = '0; m_en = 0;
  endfunction

  function automatic bit m_pass(int f, int n);
    return m_inf[f] || (((m_lim[f] - m_cc[f] - n) & 4095) < 2048);
  endfunction

  function automatic bit m_ok();
    int hf, df;
    if (!m_full) return 0;
    hf = m_type == 0 ? 0 : m_type == 1 ? 2 : 3;
    df = m_type == 0 ? 1 : 4;
    return m_pass(hf, 1) && (m_type == 1 || m_pass(df, (m_pld + 3) / 4))
           && int'(retry_buffer_leftover_cnt_i) >= m_dw;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT to model mid-cycle, then advance the model with the inputs seen at the edge.
  task automatic step();
    bit ok, acc;
    int lim_in[5];
    #2;
    chk("ready", tlp_ready_o, m_run && !m_full);
    chk("stall", stall_credit_o, m_full && !m_ok());
    chk("init", fc_init_done_o, m_run);
    chk("en", tl2dll_en_o, m_en);
    chk("data", tl2dll_data_o, m_data);
    if (tl2dll_en_o != 0) n_strobe++;
    ok = m_ok();
    acc = m_run && !m_full && tlp_valid_i;
    lim_in = '{ep_cl_p_h_i, ep_cl_p_d_i, ep_cl_np_h_i, ep_cl_cpl_h_i, ep_cl_cpl_d_i};
    @(posedge sclk);
    if (srst) m_reset();
    else begin
      m_en = ok ? 3'(1 << m_type) : 3'd0;
      if (ok) begin
        m_data = m_hdata;
        m_cc[m_type == 0 ? 0 : m_type == 1 ? 2 : 3] = (m_cc[m_type == 0 ? 0 : m_type == 1 ? 2 : 3] + 1) & 4095;
        if (m_type != 1) m_cc[m_type == 0 ? 1 : 4] = (m_cc[m_type == 0 ? 1 : 4] + (m_pld + 3) / 4) & 4095;
        m_full = 0;
      end
      if (acc && tlp_type_i != 3) begin
        m_full = 1; m_type = tlp_type_i; m_dw = tlp_dw_i; m_pld = tlp_pld_dw_i; m_hdata = tlp_data_i;
      end
      if (ep_cl_en_i)
        for (int i = 0; i < 5; i++) begin
          if (!m_run) begin m_lim[i] = lim_in[i]; m_inf[i] = lim_in[i] == 0; end
          else if (!m_inf[i]) m_lim[i] = lim_in[i];
        end
      if (ep_cl_en_i) m_run = 1;
    end
    #1;
  endtask

  task automatic send(int typ, int dw, int pld);
    bit a, done = 0;
    tlp_valid_i = 1; tlp_type_i = 2'(typ); tlp_dw_i = 4'(dw); tlp_pld_dw_i = 4'(pld);
    tlp_data_i = {8{$urandom}};
    for (int i = 0; i < 20 && !done; i++) begin
      a = m_run && !m_full;
      step();
      done = a;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL send_timeout: accepted 0, expected 1"); end
    tlp_valid_i = 0;
  endtask

  task automatic limits(int ph, int pd);
    ep_cl_en_i = 1; ep_cl_p_h_i = CD'(ph); ep_cl_p_d_i = CD'(pd);
    step();
    ep_cl_en_i = 0;
  endtask

  typedef struct {bit cl_en; int p_h; bit valid; bit e_ready; bit [2:0] e_en; bit e_stall; bit e_init;} vec_t;
  vec_t tbl[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{'{1,4,0,0,0,0,0}, '{0,4,1,1,0,0,1}, '{0,4,1,0,0,0,1}, '{0,4,1,1,1,0,1},
            '{0,4,1,0,0,0,1}, '{0,4,1,1,1,0,1}, '{0,4,1,0,0,0,1}, '{0,4,1,1,1,0,1},
            '{0,4,1,0,0,0,1}, '{0,4,1,1,1,0,1}, '{1,5,0,0,0,1,1}, '{0,5,0,0,0,0,1},
            '{0,5,0,1,1,0,1}};
    m_reset();
    repeat (2) @(posedge sclk);
    #1 srst = 0;
    retry_buffer_leftover_cnt_i = 255;
    ep_cl_p_d_i = 8; tlp_type_i = 0; tlp_dw_i = 4; tlp_pld_dw_i = 0;
    // Init plus header exhaustion: four strobes at 2-cycle spacing, fifth held until P_H grows.
    foreach (tbl[i]) begin
      ep_cl_en_i = tbl[i].cl_en; ep_cl_p_h_i = CD'(tbl[i].p_h); tlp_valid_i = tbl[i].valid;
      tlp_data_i = {8{$urandom}};
      #2;
      chk($sformatf("tbl%0d_ready", i), tlp_ready_o, tbl[i].e_ready);
      chk($sformatf("tbl%0d_en", i), tl2dll_en_o, tbl[i].e_en);
      chk($sformatf("tbl%0d_stall", i), stall_credit_o, tbl[i].e_stall);
      chk($sformatf("tbl%0d_init", i), fc_init_done_o, tbl[i].e_init);
      step();
    end
    ep_cl_en_i = 0; tlp_valid_i = 0;
    // Data credits: need 2 per TLP against P_D = 8.
    limits(100, 8);
    n_strobe = 0;
    repeat (5) send(0, 8, 5);
    repeat (3) step();
    chk("pd_strobes", n_strobe, 4);
    chk("pd_stall", stall_credit_o, 1);
    limits(100, 10);
    repeat (2) step();
    chk("pd_release", n_strobe, 5);
    // Retry space: CPL of 4 DW waits for 4 free DW, seen in the same cycle.
    retry_buffer_leftover_cnt_i = 3;
    n_strobe = 0;
    send(2, 4, 1);
    repeat (3) step();
    chk("retry_stall", stall_credit_o, 1);
    chk("retry_nostrobe", n_strobe, 0);
    retry_buffer_leftover_cnt_i = 4;
    step();
    #2 chk("retry_strobe", tl2dll_en_o, 3'b100);
    step();
    retry_buffer_leftover_cnt_i = 255;
    // Drive P header consumption up to 4094, then cross the wrap with CL = 2.
    ep_cl_en_i = 1;
    for (int g = 0; g < 5000 && m_cc[0] != 4094; g++) begin
      ep_cl_p_h_i = CD'(m_cc[0] + 4);
      send(0, 4, 0);
      step();
    end
    ep_cl_en_i = 0;
    step();
    limits(2, 10);
    n_strobe = 0;
    repeat (5) send(0, 4, 0);
    repeat (3) step();
    chk("wrap_strobes", n_strobe, 4);
    chk("wrap_stall", stall_credit_o, 1);
    // Reset while a TLP is held and stalled.
    srst = 1;
    step();
    #2;
    chk("rst_en", tl2dll_en_o, 0);
    chk("rst_ready", tlp_ready_o, 0);
    chk("rst_stall", stall_credit_o, 0);
    chk("rst_init", fc_init_done_o, 0);
    chk("rst_data", tl2dll_data_o, 0);
    srst = 0;
    repeat (2) step();
    chk("rst_wait_ready", tlp_ready_o, 0);
    // Randomized traffic with rare resets and limit updates near the consumed counts.
    for (int c = 0; c < 3000; c++) begin
      srst = $urandom_range(499) == 0;
      ep_cl_en_i = m_run ? $urandom_range(19) == 0 : $urandom_range(3) == 0;
      ep_cl_p_h_i   = CD'(m_run ? m_cc[0] + $urandom_range(11) : ($urandom_range(2) == 0 ? 0 : $urandom_range(9)));
      ep_cl_p_d_i   = CD'(m_run ? m_cc[1] + $urandom_range(11) : ($urandom_range(2) == 0 ? 0 : $urandom_range(9)));
      ep_cl_np_h_i  = CD'(m_run ? m_cc[2] + $urandom_range(11) : ($urandom_range(2) == 0 ? 0 : $urandom_range(9)));
      ep_cl_cpl_h_i = CD'(m_run ? m_cc[3] + $urandom_range(11) : ($urandom_range(2) == 0 ? 0 : $urandom_range(9)));
      ep_cl_cpl_d_i = CD'(m_run ? m_cc[4] + $urandom_range(11) : ($urandom_range(2) == 0 ? 0 : $urandom_range(9)));
      tlp_valid_i = $urandom_range(9) < 7;
      tlp_type_i = 2'($urandom_range(3));
      tlp_dw_i = 4'($urandom_range(8, 1));
      tlp_pld_dw_i = 4'($urandom_range(5));
      tlp_data_i = {8{$urandom}};
      retry_buffer_leftover_cnt_i = RD'($urandom_range(11));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
